mul_add_pipe: RTL and testbench

//   Fully pipelined shift-add multiply-accumulate: product = merchant*divisor + remainder.

---
 rtl/mul_add_pipe.sv | 81 ++++++++
 tb/tb_mul_add_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_add_pipe.sv
// Fully pipelined shift-add multiply-accumulate: product = merchant*divisor + remainder.
// M stages, one partial product per stage, one operation per cycle, whole-pipe stall on hold.
module mul_add_pipe #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           data_rdy,
  input  logic           hold,
  input  logic [N-1:0]   merchant,
  input  logic [M-1:0]   divisor,
  input  logic [M-1:0]   remainder,
  output logic           res_rdy,
  output logic [N+M-1:0] product
);

  localparam int W = N + M;

  logic [M-1:0] vld_q, vld_d;
  logic [W-1:0] acc_q   [M];
  logic [W-1:0] acc_d   [M];
  logic [W-1:0] a_sh_q  [M];
  logic [W-1:0] a_sh_d  [M];
  logic [M-1:0] b_rem_q [M];
  logic [M-1:0] b_rem_d [M];

  // Partial product for one multiplier bit: the shifted multiplicand or nothing.
  function automatic logic [W-1:0] pp_sel(input logic [W-1:0] a, input logic sel);
    return sel ? a : '0;
  endfunction

  always_comb begin
    for (int k = 0; k < M; k++) begin
      vld_d[k]   = vld_q[k];
      acc_d[k]   = acc_q[k];
      a_sh_d[k]  = a_sh_q[k];
      b_rem_d[k] = b_rem_q[k];
    end
    if (!hold) begin
      // S0: seed the accumulator with the addend plus the first partial product
      vld_d[0]   = data_rdy;
      acc_d[0]   = W'(remainder) + pp_sel(W'(merchant), divisor[0]);
      a_sh_d[0]  = W'(merchant) << 1;
      b_rem_d[0] = divisor >> 1;
      // S1..S(M-1): consume one multiplier bit per stage
      for (int k = 1; k < M; k++) begin
        vld_d[k]   = vld_q[k-1];
        acc_d[k]   = acc_q[k-1] + pp_sel(a_sh_q[k-1], b_rem_q[k-1][0]);
        a_sh_d[k]  = a_sh_q[k-1] << 1;
        b_rem_d[k] = b_rem_q[k-1] >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int k = 0; k < M; k++) begin
        acc_q[k]   <= '0;
        a_sh_q[k]  <= '0;
        b_rem_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < M; k++) begin
        acc_q[k]   <= acc_d[k];
        a_sh_q[k]  <= a_sh_d[k];
        b_rem_q[k] <= b_rem_d[k];
      end
    end
  end

  // Last-stage shifter state has no consumer; it is kept only for a uniform stage layout.
  logic unused_tail;
  assign unused_tail = ^{a_sh_q[M-1], b_rem_q[M-1]};

  assign res_rdy = vld_q[M-1];
  assign product = acc_q[M-1];

endmodule

// File: tb/tb_mul_add_pipe.sv
// Directed self-checking bench for mul_add_pipe (N=M=8): latency, bubbles, hold, reset, round trip.
module tb_mul_add_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        data_rdy;
  logic        hold;
  logic [7:0]  merchant;
  logic [7:0]  divisor;
  logic [7:0]  remainder;
  logic        res_rdy;
  logic [15:0] product;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  mul_add_pipe #(.N(8), .M(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_rdy  (data_rdy),
    .hold      (hold),
    .merchant  (merchant),
    .divisor   (divisor),
    .remainder (remainder),
    .res_rdy   (res_rdy),
    .product   (product)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [15:0] val);
    chk({tag, ".rdy"}, {31'd0, res_rdy}, {31'd0, rdy});
    if (rdy) chk({tag, ".prod"}, {16'd0, product}, {16'd0, val});
  endtask

  task automatic drive(input logic dr, input logic [7:0] m, input logic [7:0] d, input logic [7:0] r);
    data_rdy  = dr;
    merchant  = m;
    divisor   = d;
    remainder = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    hold = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    #1;

    // 1. reset with data_rdy high and random operands
    rstn = 1'b0;
    drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    step();
    drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    step();
    chk("rst.rdy", {31'd0, res_rdy}, 32'd0);
    chk("rst.prod", {16'd0, product}, 32'd0);
    rstn = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rst.idle%0d", i), {31'd0, res_rdy}, 32'd0);
    end

    // 2. single op: 48*5+0 = 240 exactly after edge t+7
    drive(1'b1, 8'd48, 8'd5, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 1; i < 7; i++) begin
      step();
      chk_out($sformatf("single.wait%0d", i), 1'b0, 16'd0);
    end
    step();
    chk_out("single.res", 1'b1, 16'd240);
    step();
    chk_out("single.after", 1'b0, 16'd0);

    // 3. back-to-back, bubble, then a zero multiplicand
    drive(1'b1, 8'd5, 8'd3, 8'd1);   step();
    drive(1'b1, 8'd2, 8'd4, 8'd2);   step();
    drive(1'b1, 8'd15, 8'd1, 8'd0);  step();
    drive(1'b0, 8'd99, 8'd99, 8'd99); step();
    drive(1'b1, 8'd0, 8'd7, 8'd6);   step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step(); chk_out("b2b.wait5", 1'b0, 16'd0);
    step(); chk_out("b2b.wait6", 1'b0, 16'd0);
    step(); chk_out("b2b.r0", 1'b1, 16'd16);
    step(); chk_out("b2b.r1", 1'b1, 16'd10);
    step(); chk_out("b2b.r2", 1'b1, 16'd15);
    step(); chk_out("b2b.bubble", 1'b0, 16'd0);
    step(); chk_out("b2b.r3", 1'b1, 16'd6);
    step(); chk_out("b2b.after", 1'b0, 16'd0);

    // 4. extremes
    drive(1'b1, 8'd255, 8'd255, 8'd255); step();
    drive(1'b1, 8'd255, 8'd0, 8'd7);     step();
    drive(1'b1, 8'd0, 8'd255, 8'd0);     step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 3; i < 7; i++) begin
      step();
      chk_out($sformatf("ext.wait%0d", i), 1'b0, 16'd0);
    end
    step(); chk_out("ext.max", 1'b1, 16'd65280);
    step(); chk_out("ext.div0", 1'b1, 16'd7);
    step(); chk_out("ext.m0", 1'b1, 16'd0);
    step(); chk_out("ext.after", 1'b0, 16'd0);

    // 5. hold for 4 edges while ops sit in S2..S4
    drive(1'b1, 8'd10, 8'd10, 8'd10);   step();
    drive(1'b1, 8'd7, 8'd9, 8'd3);      step();
    drive(1'b1, 8'd100, 8'd200, 8'd50); step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i[0] == 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      step();
      chk_out($sformatf("hold.frozen%0d", i), 1'b0, 16'd0);
    end
    hold = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step(); chk_out("hold.wait9", 1'b0, 16'd0);
    step(); chk_out("hold.wait10", 1'b0, 16'd0);
    step(); chk_out("hold.r0", 1'b1, 16'd110);
    step(); chk_out("hold.r1", 1'b1, 16'd66);
    step(); chk_out("hold.r2", 1'b1, 16'd20050);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out($sformatf("hold.extra%0d", i), 1'b0, 16'd0);
    end

    // 6a. reset with 5 ops in flight discards them all
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'(i * 11), 8'(i * 3), 8'(i));
      step();
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    rstn = 1'b0;
    step();
    chk("midrst.prod", {16'd0, product}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("midrst.quiet%0d", i), {31'd0, res_rdy}, 32'd0);
      step();
    end

    // 6b. round trip: feed divider results back, expect the original dividend
    for (int d = 1; d <= 7; d++) begin
      for (int x = 0; x < 256; x++) begin
        drive(1'b1, 8'(x / d), 8'(d), 8'(x % d));
        exp_q.push_back(x);
        step();
        if (res_rdy) begin
          if (exp_q.size() == 0) chk("rt.extra", {31'd0, res_rdy}, 32'd0);
          else chk($sformatf("rt.d%0d", d), {16'd0, product}, 32'(exp_q.pop_front()));
        end
      end
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_rdy) begin
        if (exp_q.size() == 0) chk("rt.drain_extra", {31'd0, res_rdy}, 32'd0);
        else chk("rt.drain", {16'd0, product}, 32'(exp_q.pop_front()));
      end
    end
    chk("rt.leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
